// File: rtl/ct_f_spsram_bwe_init.sv
// Parametrised FPGA single-port SRAM with per-bit write mask, Q hold,
// optional output register and a post-reset hardware init sweep.
module ct_f_spsram_bwe_init #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 23,
    parameter int OUT_REG    = 0,
    parameter int INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_DONE
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_next;
    logic                    done_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    user_rd;
    logic                    user_wr;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   shadow_rd;
    logic [DATA_WIDTH-1:0]   merged;

    logic [DATA_WIDTH-1:0]   stage;
    logic                    stage_valid;

    // User accesses are only honoured once the sweep has finished.
    assign user_rd = (state == ST_RUN) && !CEN &&  GWEN;
    assign user_wr = (state == ST_RUN) && !CEN && !GWEN;

    // Shadow read port feeds the bit-merge so the write port always writes a full word.
    assign shadow_rd = mem[A];
    assign merged    = (shadow_rd & WEN) | (D & ~WEN);

    // FSM state, sweep counter and ready flag.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= ST_INIT;
            cnt       <= '0;
            INIT_DONE <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state     <= state_next;
            cnt       <= cnt_next;
            INIT_DONE <= done_next;
        end
    end

    // Next-state logic: sweep cnt 0..DEPTH-1, leave INIT on the last write.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        done_next  = INIT_DONE;
        case (state)
            ST_INIT: begin
                if (INIT_EN == 0) begin
                    state_next = ST_RUN;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + ADDR_WIDTH'(1);
                    if (&cnt) begin
                        state_next = ST_RUN;
                        done_next  = 1'b1;
                        cnt_next   = '0;
                    end
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Write-port mux: the sweep owns the port during INIT, the user during RUN.
    always_comb begin
        mem_we    = user_wr;
        mem_addr  = A;
        mem_wdata = merged;
        if (state == ST_INIT) begin
            // RSTB gates the sweep write so holding reset never touches the array.
            mem_we    = (INIT_EN != 0) && RSTB;
            mem_addr  = cnt;
            mem_wdata = INIT_VALUE;
        end
    end

    // Array write port.
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset; clearing it is the sweep's job, and a
        // reset term here would stop the tools from mapping it onto block RAM.
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Synchronous read, optional output stage, Q held between reads.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            stage       <= '0;
            stage_valid <= 1'b0;
            Q           <= '0;
        end else begin
            stage_valid <= user_rd;
            if (user_rd) begin
                stage <= mem[A];
            end
            if (OUT_REG == 0) begin
                if (user_rd) begin
                    Q <= mem[A];
                end
            end else if (stage_valid) begin
                Q <= stage;
            end
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_bwe_init.sv
// Directed bench: one OUT_REG=0 and one OUT_REG=1 instance share all stimulus.
module tb_ct_f_spsram_bwe_init;

    logic        clk;
    logic        rstb;
    logic [7:0]  a;
    logic        cen;
    logic        gwen;
    logic [22:0] wen;
    logic [22:0] d;
    logic [22:0] q0;
    logic [22:0] q1;
    logic        done0;
    logic        done1;

    int checks;
    int failures;

    ct_f_spsram_bwe_init #(
        .ADDR_WIDTH(8), .DATA_WIDTH(23), .OUT_REG(0), .INIT_EN(1), .INIT_VALUE(23'h0)
    ) u0 (
        .CLK(clk), .RSTB(rstb), .A(a), .CEN(cen), .GWEN(gwen),
        .WEN(wen), .D(d), .Q(q0), .INIT_DONE(done0)
    );

    ct_f_spsram_bwe_init #(
        .ADDR_WIDTH(8), .DATA_WIDTH(23), .OUT_REG(1), .INIT_EN(1), .INIT_VALUE(23'h0)
    ) u1 (
        .CLK(clk), .RSTB(rstb), .A(a), .CEN(cen), .GWEN(gwen),
        .WEN(wen), .D(d), .Q(q1), .INIT_DONE(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic g, input logic [7:0] ad,
                          input logic [22:0] w, input logic [22:0] dd);
        cen  = c;
        gwen = g;
        a    = ad;
        wen  = w;
        d    = dd;
    endtask

    task automatic do_write(input logic [7:0] ad, input logic [22:0] dd, input logic [22:0] w);
        set_in(1'b0, 1'b0, ad, w, dd);
        step();
    endtask

    task automatic do_read(input logic [7:0] ad);
        set_in(1'b0, 1'b1, ad, '1, '0);
        step();
    endtask

    task automatic do_idle();
        set_in(1'b1, 1'b1, '0, '1, '0);
        step();
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b1, '0, '1, '0);
        rstb = 1'b1;
        #1 rstb = 1'b0;
        step();
        step();
        checks++;
        if (q0 !== 23'h0 || q1 !== 23'h0) begin
            failures++;
            $display("FAIL reset_q: got q0=%h q1=%h expected 0", q0, q1);
        end
        checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b/%b expected 0", done0, done1);
        end
    endtask

    task automatic test_init_sweep();
        int n;
        n = 0;
        @(negedge clk);
        rstb = 1'b1;
        while (done0 !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL init_edges: got %0d expected 256", n);
        end
        checks++;
        if (done1 !== 1'b1) begin
            failures++;
            $display("FAIL init_done_outreg: got %b expected 1", done1);
        end
        do_read(8'd0);
        checks++;
        if (q0 !== 23'h0) begin
            failures++;
            $display("FAIL init_read0: got %h expected 0", q0);
        end
        do_read(8'd127);
        checks++;
        if (q0 !== 23'h0) begin
            failures++;
            $display("FAIL init_read127: got %h expected 0", q0);
        end
        do_read(8'd255);
        checks++;
        if (q0 !== 23'h0) begin
            failures++;
            $display("FAIL init_read255: got %h expected 0", q0);
        end
    endtask

    task automatic test_bit_mask();
        do_write(8'h10, 23'h7FFFFF, 23'h000000);
        do_write(8'h10, 23'h000000, 23'h7FFF00);
        do_read(8'h10);
        checks++;
        if (q0 !== 23'h7FFF00) begin
            failures++;
            $display("FAIL bit_mask: got %h expected 7fff00", q0);
        end
    endtask

    task automatic test_q_hold();
        do_read(8'h10);
        checks++;
        if (q0 !== 23'h7FFF00) begin
            failures++;
            $display("FAIL hold_read: got %h expected 7fff00", q0);
        end
        for (int i = 0; i < 3; i++) begin
            do_idle();
            checks++;
            if (q0 !== 23'h7FFF00 || q1 !== 23'h7FFF00) begin
                failures++;
                $display("FAIL hold_idle%0d: got q0=%h q1=%h expected 7fff00", i, q0, q1);
            end
        end
        do_write(8'h20, 23'h2A5A5A, 23'h000000);
        checks++;
        if (q0 !== 23'h7FFF00 || q1 !== 23'h7FFF00) begin
            failures++;
            $display("FAIL hold_write: got q0=%h q1=%h expected 7fff00", q0, q1);
        end
        do_read(8'h20);
        checks++;
        if (q0 !== 23'h2A5A5A) begin
            failures++;
            $display("FAIL hold_newread: got %h expected 2a5a5a", q0);
        end
        do_idle();
        checks++;
        if (q1 !== 23'h2A5A5A) begin
            failures++;
            $display("FAIL hold_newread_outreg: got %h expected 2a5a5a", q1);
        end
    endtask

    task automatic test_write_read();
        do_write(8'd5, 23'h000055, 23'h000000);
        do_read(8'd5);
        checks++;
        if (q0 !== 23'h000055) begin
            failures++;
            $display("FAIL wr_rd_same: got %h expected 000055", q0);
        end
        do_idle();
        checks++;
        if (q1 !== 23'h000055) begin
            failures++;
            $display("FAIL wr_rd_same_outreg: got %h expected 000055", q1);
        end
    endtask

    task automatic test_back_to_back();
        do_write(8'd0, 23'h1, 23'h0);
        do_write(8'd1, 23'h2, 23'h0);
        do_write(8'd2, 23'h3, 23'h0);
        do_read(8'd0);
        checks++;
        if (q0 !== 23'h1) begin
            failures++;
            $display("FAIL b2b_n_q0: got %h expected 1", q0);
        end
        do_read(8'd1);
        checks++;
        if (q0 !== 23'h2 || q1 !== 23'h1) begin
            failures++;
            $display("FAIL b2b_n1: got q0=%h q1=%h expected 2/1", q0, q1);
        end
        do_read(8'd2);
        checks++;
        if (q0 !== 23'h3 || q1 !== 23'h2) begin
            failures++;
            $display("FAIL b2b_n2: got q0=%h q1=%h expected 3/2", q0, q1);
        end
        do_idle();
        checks++;
        if (q0 !== 23'h3 || q1 !== 23'h3) begin
            failures++;
            $display("FAIL b2b_n3: got q0=%h q1=%h expected 3/3", q0, q1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        // Reset from RUN with Q non-zero: outputs clear without a clock edge.
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (q0 !== 23'h0 || q1 !== 23'h0 || done0 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_run: got q0=%h q1=%h done=%b/%b expected 0", q0, q1, done0, done1);
        end
        // Sweep with user writes pending, interrupted at cycle 100.
        set_in(1'b0, 1'b0, 8'h33, 23'h000000, 23'h001234);
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 100; i++) step();
        checks++;
        if (done0 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_not_done_at_100: got %b expected 0", done0);
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (done0 !== 1'b0 || q0 !== 23'h0 || q1 !== 23'h0) begin
            failures++;
            $display("FAIL async_reset_sweep: got done=%b q0=%h q1=%h expected 0", done0, q0, q1);
        end
        set_in(1'b0, 1'b0, 8'h10, 23'h000000, 23'h005A5A);
        @(negedge clk);
        rstb = 1'b1;
        n = 0;
        while (done0 !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL resweep_edges: got %0d expected 256", n);
        end
        do_write(8'h40, 23'h000007, 23'h000000);
        do_read(8'h40);
        checks++;
        if (q0 !== 23'h000007) begin
            failures++;
            $display("FAIL post_sweep_write: got %h expected 000007", q0);
        end
        do_read(8'h33);
        checks++;
        if (q0 !== 23'h0) begin
            failures++;
            $display("FAIL sweep_blocks_user_write: got %h expected 0", q0);
        end
        do_read(8'h10);
        checks++;
        if (q0 !== 23'h0) begin
            failures++;
            $display("FAIL sweep_clears_old: got %h expected 0", q0);
        end
        do_idle();
        checks++;
        if (q1 !== 23'h0) begin
            failures++;
            $display("FAIL sweep_clears_old_outreg: got %h expected 0", q1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_init_sweep();
        test_bit_mask();
        test_q_hold();
        test_write_read();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ct_f_spsram_bwe_init.md
Name: ct_f_spsram_bwe_init

Overview:
- Parametrised FPGA single-port SRAM model. Direct successor of the fixed-size spsram FPGA wrappers.
- Honours the full per-bit write mask WEN, not only WEN[0].
- Holds Q between reads and has an optional output register stage.
- Runs a hardware init sweep after reset, so tag, valid and LRU arrays come up cleared without a software flush.
- Instantiated in place of the fixed-size ct_f_spsram_* wrappers in FPGA builds.

Parameters:
- ADDR_WIDTH, 8: address bits. DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 23: word width in bits.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register, giving 2-cycle latency.
- INIT_EN, 1: 1 enables the post-reset init sweep; 0 makes the array contents undefined after reset.
- INIT_VALUE, 0: DATA_WIDTH-bit value written to every word during the sweep.

Ports:
- CLK  in  1  clock, rising edge.
- RSTB  in  1  asynchronous active-low reset.
- A  in  ADDR_WIDTH  address.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low. 0 = write, 1 = read.
- WEN  in  DATA_WIDTH  per-bit write enable, active low.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- INIT_DONE  out  1  1 = array is ready and accepts accesses.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (CLK, RSTB).
- Reset values: Q = 0; INIT_DONE = 0; FSM in INIT (or DONE-pending when INIT_EN = 0); init counter = 0; OUT_REG pipe valid = 0.
- RSTB does not clear the array; only the sweep clears it.
- FSM has two states, INIT and RUN.
  - INIT_EN = 1: after RSTB rises, INIT writes INIT_VALUE to address cnt on every edge, cnt going 0 to DEPTH-1.
  - The INIT write at cnt = DEPTH-1 also moves the FSM to RUN and sets INIT_DONE = 1 at that same edge. The sweep is exactly DEPTH cycles.
  - INIT_EN = 0: the first edge after reset release sets RUN and INIT_DONE = 1.
- During INIT:
  - CEN, GWEN, WEN, A and D are ignored.
  - No user write reaches the array.
  - Q stays 0.
- RSTB asserted mid-sweep: everything returns to reset values immediately (async); the sweep restarts from address 0 after release.
- Read (RUN, CEN = 0, GWEN = 1):
  - OUT_REG = 0: Q = mem[A] after the same edge.
  - OUT_REG = 1: data is captured into an internal stage at edge N and driven on Q after edge N+1.
- Write (RUN, CEN = 0, GWEN = 0):
  - For each bit i, mem[A][i] <= D[i] if WEN[i] = 0, otherwise the bit is unchanged.
  - WEN all ones means no change.
  - Q is not updated by a write cycle; it holds its previous value.
- Idle (CEN = 1): array unchanged; Q holds.
- OUT_REG = 1 pipeline:
  - A valid bit tracks each read.
  - Q updates only when valid data reaches the output stage; write and idle cycles never disturb Q.
  - Back-to-back reads stream one word per cycle.
- Read of an address written on the previous cycle returns the merged new data; there is no bypass hazard.
- Address wrap: A is exactly ADDR_WIDTH bits, so there is no out-of-range case.
- Simultaneous reset and access: reset wins.
- Array: behavioural reg array, DEPTH x DATA_WIDTH, coded so FPGA tools infer block RAM with bit-write via a read-merge.
  - A second, shadow read port is permitted for the merge.
  - The merge must not add user-visible latency.

Test Plan:
- INIT_EN = 1, ADDR_WIDTH = 8: release RSTB, count edges until INIT_DONE rises → exactly 256 edges. Then read addresses 0, 127 and 255 → Q = 0 each, 1 cycle after CEN = 0.
- Bit mask, DATA_WIDTH = 23, after init:
  - Write A = 0x10, D = 0x7FFFFF, WEN = 0x000000.
  - Write A = 0x10, D = 0x000000, WEN = 0x7FFF00.
  - Read A = 0x10 → Q = 0x7FFF00.
- Q hold:
  - Read A = 0x10 → Q = 0x7FFF00.
  - Then 3 idle cycles plus 1 write to A = 0x20 → Q stays 0x7FFF00 throughout.
  - Read A = 0x20 → new data.
- Reset mid-sweep:
  - Assert RSTB at sweep cycle 100 → INIT_DONE = 0 and Q = 0 immediately.
  - After release, INIT_DONE rises after 256 more edges.
  - User writes issued during the sweep are absent: reading back gives INIT_VALUE.
- OUT_REG = 1:
  - Write 0x1, 0x2, 0x3 to addresses 0, 1, 2.
  - Issue back-to-back reads of addresses 0, 1, 2 at edges N, N+1, N+2 → Q = 0x1, 0x2, 0x3 after edges N+1, N+2, N+3.
- Write then read same address:
  - Write A = 5, D = 0x55, full mask, at edge N.
  - Read A = 5 at edge N+1 → Q = 0x55 after edge N+1 (OUT_REG = 0).
